encoder_8to3: RTL and testbench
===============================

Name: encoder_8to3

Overview:
- Registered 8-to-3 priority encoder; the highest-index asserted input bit wins.
- Produces a binary index plus a valid flag (any input bit set) and a multi-hot flag.
- Leaf utility block used wherever a one-hot or multi-hot request vector must become an index, e.g. interrupt or request selection.

Parameters:
- IN_W, default 8, input vector width; must be a power of two, at least 2.
- OUT_W, default 3, output index width; must equal log2(IN_W).

Ports:
- clk    input   1      rising-edge clock.
- rst    input   1      asynchronous, active-high reset.
- en     input   1      capture enable; when high, outputs update on the clock edge.
- in     input   IN_W   request vector; bit i requests index i.
- out    output  OUT_W  encoded index of the highest set bit of in.
- valid  output  1      1 when at least one bit of the sampled in was set.
- multi  output  1      1 when two or more bits of the sampled in were set.

Behaviour:
- One clock domain. All outputs come straight from flops; there is no combinational path from in to any output.
- Reset:
  - rst high asynchronously forces out=0, valid=0, multi=0, independent of clk.
  - Outputs hold these values until the first rising edge with rst low and en high.
- Latency: exactly 1 cycle. in sampled at edge N with en=1 appears on the outputs after edge N.
- en=0: all outputs hold their previous values; in is ignored.
- Encoding, applied when en=1:
  - out = largest index i such that in[i]=1.
  - Priority order is fixed: bit IN_W-1 highest, bit 0 lowest.
- valid = OR of all bits of in.
- multi = 1 when popcount(in) ≥ 2, else 0.
- Zero input: in=0 gives out=0, valid=0, multi=0. out=0 with valid=0 means "no request". out=0 with valid=1 means bit 0 only.
- Single-hot input: out = bit position, valid=1, multi=0.
- Multi-hot input: highest set bit wins, valid=1, multi=1. Example: 8'b11010101 gives out=3'b111.
- Reset mid-operation: rst asserted between edges clears the outputs immediately. The first edge after release with en=1 loads fresh values; there is no stale-data carry-over.
- X or Z on in is not supported. Outputs are undefined for such input and the bench must not drive it.
- The implementation must be generic in IN_W, using a loop or tree, not a hard-coded 8-way case.

Decomposition:
- Shared package enc_pkg holds:
  - localparam ENC_IN_W = 8 and ENC_OUT_W = $clog2(ENC_IN_W);
  - a typedef for the index type;
  - a pure function highest_set_idx(vector) returning index and any-bit flag, reused by the RTL and the bench scoreboard.
- One sub-module is natural: prio_enc_core.
  - Purely combinational; computes index, any and multi from in.
  - encoder_8to3 wraps it with the enable-gated, asynchronously reset output register.

Test Plan:
- Reset: drive rst=1 with in=8'hFF and en=1 -> out=000, valid=0, multi=0 immediately, without waiting for a clock edge. Release rst; one edge later -> out=111, valid=1, multi=1.
- Walking one: en=1, in from 8'h00, then 8'h01, 8'h02 … through 8'h80, one value per cycle, checked one cycle later:
  - 8'h00 -> out=000, valid=0, multi=0;
  - 8'h01 … 8'h80 -> out=000 … 111, valid=1, multi=0.
- Priority: in=8'b11010101 -> out=111, valid=1, multi=1. in=8'b00010101 -> out=100, multi=1. in=8'b00000011 -> out=001, multi=1.
- Enable hold: load in=8'h20 (out=101). Set en=0 and drive in=8'h01 for 3 cycles -> out stays 101, valid stays 1. Set en=1 -> next cycle out=000, valid=1.
- Async reset mid-stream: with out=110 and valid=1, pulse rst between clock edges -> outputs clear at once. After release with in=8'h08 -> out=011 one cycle later.
- Random: 1000 random in values with random en, compared every cycle against highest_set_idx from enc_pkg, delayed one cycle and gated by en.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: shared widths, index type and reference priority function for the encoder
package enc_pkg;
  localparam int ENC_IN_W = 8;
  localparam int ENC_OUT_W = $clog2(ENC_IN_W);
  typedef logic [ENC_OUT_W-1:0] idx_t;
  typedef struct packed {
    idx_t idx;
    logic any;
  } hsi_t;
  function automatic hsi_t highest_set_idx(input logic [ENC_IN_W-1:0] v);
    hsi_t r;
    r = '0;
    for (int i = ENC_IN_W - 1; i >= 0; i--)
      if (v[i] && !r.any) begin
        r.idx = idx_t'(i);
        r.any = 1'b1;
      end
    return r;
  endfunction
endpackage

// File: rtl/encoder_8to3_core.sv
// prio_enc_core: combinational priority encoder, highest set bit wins, plus any/multi flags
module prio_enc_core
  import enc_pkg::*;
#(
  parameter int IN_W = ENC_IN_W,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);
  // ascending scan: later (higher) set bits overwrite the index
  always_comb begin
    idx = '0;
    any = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < IN_W; i++)
      if (in[i]) begin
        multi = multi | any;
        any = 1'b1;
        idx = OUT_W'(i);
      end
  end
endmodule

// File: rtl/encoder_8to3.sv
// encoder_8to3: registered priority encoder with capture enable and async reset
module encoder_8to3
  import enc_pkg::*;
#(
  parameter int IN_W = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             multi
);
  logic [OUT_W-1:0] idx;
  logic any, mh;
  prio_enc_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in(in),
    .idx(idx),
    .any(any),
    .multi(mh)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else if (en) begin
      out <= idx;
      valid <= any;
      multi <= mh;
    end
endmodule

// File: tb/tb_encoder_8to3.sv
// tb_encoder_8to3: scoreboard bench, stimulus pushes expectations, monitor pops after each edge
module tb_encoder_8to3;
  import enc_pkg::*;
  typedef struct {
    string n;
    idx_t o;
    logic v;
    logic m;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] in = '0;
  idx_t out;
  logic valid, multi;
  exp_t q[$];
  exp_t model;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  encoder_8to3 dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .out(out),
    .valid(valid),
    .multi(multi)
  );

  function automatic exp_t mk(input string n, input idx_t o, input logic v, input logic m);
    exp_t w;
    w.n = n;
    w.o = o;
    w.v = v;
    w.m = m;
    return w;
  endfunction

  task automatic check(input exp_t w);
    total++;
    if ({out, valid, multi} !== {w.o, w.v, w.m}) begin
      bad++;
      $display("FAIL %s: got out=%0d valid=%0b multi=%0b, want out=%0d valid=%0b multi=%0b",
               w.n, out, valid, multi, w.o, w.v, w.m);
    end
  endtask

  task automatic step(input logic e, input logic [7:0] v, input exp_t w);
    @(negedge clk);
    rst = 1'b0;
    en = e;
    in = v;
    model = w;
    q.push_back(w);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) check(q.pop_front());
  end

  initial begin
    hsi_t h;
    exp_t w;
    logic e;
    logic [7:0] v;
    in = 8'hFF;
    en = 1'b1;
    #3 check(mk("rst_async", 3'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1 check(mk("rst_hold", 3'd0, 1'b0, 1'b0));
    step(1'b1, 8'hFF, mk("rst_release", 3'd7, 1'b1, 1'b1));
    step(1'b1, 8'h00, mk("walk_zero", 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'(1 << i), mk($sformatf("walk_%0d", i), idx_t'(i), 1'b1, 1'b0));
    step(1'b1, 8'b11010101, mk("prio_d5", 3'd7, 1'b1, 1'b1));
    step(1'b1, 8'b00010101, mk("prio_15", 3'd4, 1'b1, 1'b1));
    step(1'b1, 8'b00000011, mk("prio_03", 3'd1, 1'b1, 1'b1));
    step(1'b1, 8'h20, mk("hold_load", 3'd5, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h01, mk($sformatf("hold_%0d", i), 3'd5, 1'b1, 1'b0));
    step(1'b1, 8'h01, mk("hold_release", 3'd0, 1'b1, 1'b0));
    step(1'b1, 8'h40, mk("pre_rst", 3'd6, 1'b1, 1'b0));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check(mk("rst_mid", 3'd0, 1'b0, 1'b0));
    model = mk("rst_mid", 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h08, mk("post_rst", 3'd3, 1'b1, 1'b0));
    for (int i = 0; i < 1000; i++) begin
      e = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      if (e) begin
        h = highest_set_idx(v);
        w = mk("rand", h.idx, h.any, $countones(v) >= 2);
      end else begin
        w = model;
        w.n = "rand_hold";
      end
      step(e, v, w);
    end
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
